// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement subtractor, DIFF = A - B,
// one bit per clock, LSB first, with a single registered borrow.
// START/BUSY/DONE handshake; one result per WIDTH+1 cycles when back to back.
// Optional macro SERIAL_SUB_OVF_EN adds the signed overflow output OVF.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] DIFF,
  output logic             BOUT
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int unsigned   CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  // Holds the WIDTH-1 bits already produced; the bit being computed on the
  // load edge is appended directly, so no flop ever holds a dead LSB.
  logic [WIDTH-2:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] res_shifted;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;
`endif

  // One subtractor cell acting on the current LSBs and the stored borrow
  always_comb begin
    d_bit       = a_q[0] ^ b_q[0] ^ br_q;
    br_next     = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    res_shifted = {d_bit, res_q};
  end

  // Next-state, capture, shift and result-load logic
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    br_d    = br_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          a_d     = A;
          b_d     = B;
          br_d    = 1'b0;
          cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d = A[WIDTH-1];
          b_msb_d = B[WIDTH-1];
`endif
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        res_d = res_shifted[WIDTH-1:1];
        br_d  = br_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          diff_d  = res_shifted;
          bout_d  = br_next;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = (a_msb_q ^ b_msb_q) & (a_msb_q ^ d_bit);
`endif
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign BUSY = (state_q == S_RUN);
  assign DONE = (state_q == S_DONE);
  assign DIFF = diff_q;
  assign BOUT = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign OVF  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed self-checking bench for serial_subtractor
// at WIDTH=8; OVF checks are included when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

  logic       CLK;
  logic       RST;
  logic       START;
  logic [7:0] A;
  logic [7:0] B;
  logic       BUSY;
  logic       DONE;
  logic [7:0] DIFF;
  logic       BOUT;
`ifdef SERIAL_SUB_OVF_EN
  logic       OVF;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  last_diff = 8'h00;

  serial_subtractor #(.WIDTH(8)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .A     (A),
    .B     (B),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .DIFF  (DIFF),
    .BOUT  (BOUT)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .OVF   (OVF)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input string what,
                       input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One full operation from an idle/done state; optional mid-run START poke
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_d, input logic exp_b,
                        input logic exp_o, input logic poke, input string tag);
    @(negedge CLK);
    A = a; B = b; START = 1'b1;
    tick();  // E0
    START = 1'b0;
    check(tag, "busy_e0", {31'b0, BUSY}, 32'd1);
    for (int i = 1; i < 8; i++) begin
      tick();
      if (poke && i == 4) START = 1'b0;
      check(tag, "busy_run", {31'b0, BUSY}, 32'd1);
      check(tag, "diff_hold", {24'b0, DIFF}, {24'b0, last_diff});
      if (poke && i == 3) begin
        @(negedge CLK);
        A = 8'h77; B = 8'h11; START = 1'b1;
      end
    end
    tick();  // E8
    check(tag, "done", {31'b0, DONE}, 32'd1);
    check(tag, "busy_e8", {31'b0, BUSY}, 32'd0);
    check(tag, "diff", {24'b0, DIFF}, {24'b0, exp_d});
    check(tag, "bout", {31'b0, BOUT}, {31'b0, exp_b});
`ifdef SERIAL_SUB_OVF_EN
    check(tag, "ovf", {31'b0, OVF}, {31'b0, exp_o});
`else
    if (exp_o) $display("note: %s expects OVF=1 (feature not built)", tag);
`endif
    last_diff = exp_d;
    tick();
    check(tag, "done_pulse", {31'b0, DONE}, 32'd0);
    check(tag, "idle_busy", {31'b0, BUSY}, 32'd0);
    check(tag, "diff_after", {24'b0, DIFF}, {24'b0, exp_d});
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; A = 8'h00; B = 8'h00;
    tick();
    tick();
    check("reset", "busy", {31'b0, BUSY}, 32'd0);
    check("reset", "done", {31'b0, DONE}, 32'd0);
    check("reset", "diff", {24'b0, DIFF}, 32'd0);
    check("reset", "bout", {31'b0, BOUT}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("reset", "ovf", {31'b0, OVF}, 32'd0);
`endif
    RST = 1'b0;

    run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0, "sub_5_3");
    run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0, "sub_3_5");
    run_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "sub_0_0");
    run_op(8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0, "sub_ff_1");
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0, "sub_80_1");
    run_op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 1'b0, "sub_10_1");
    run_op(8'h40, 8'h41, 8'hFF, 1'b1, 1'b0, 1'b1, "midrun_start");

    // START held high across DONE: second op accepted at E9, done at E17
    @(negedge CLK);
    A = 8'h05; B = 8'h03; START = 1'b1;
    tick();  // E0
    for (int i = 1; i < 8; i++) tick();
    tick();  // E8
    check("held", "done_e8", {31'b0, DONE}, 32'd1);
    check("held", "diff_e8", {24'b0, DIFF}, 32'h02);
    @(negedge CLK);
    A = 8'h20; B = 8'h30;
    tick();  // E9
    check("held", "busy_e9", {31'b0, BUSY}, 32'd1);
    check("held", "done_e9", {31'b0, DONE}, 32'd0);
    check("held", "diff_e9", {24'b0, DIFF}, 32'h02);
    @(negedge CLK);
    START = 1'b0;
    for (int i = 10; i < 17; i++) tick();
    check("held", "busy_e16", {31'b0, BUSY}, 32'd1);
    tick();  // E17
    check("held", "done_e17", {31'b0, DONE}, 32'd1);
    check("held", "diff_e17", {24'b0, DIFF}, 32'hF0);
    check("held", "bout_e17", {31'b0, BOUT}, 32'd1);
    tick();
    check("held", "idle", {31'b0, BUSY | DONE}, 32'd0);
    last_diff = 8'hF0;

    // Asynchronous reset in the middle of an operation
    @(negedge CLK);
    A = 8'h05; B = 8'h03; START = 1'b1;
    tick();  // E0
    START = 1'b0;
    for (int i = 1; i < 4; i++) tick();
    @(posedge CLK);  // E4
    #2;
    RST = 1'b1;
    #1;
    check("abort", "busy", {31'b0, BUSY}, 32'd0);
    check("abort", "done", {31'b0, DONE}, 32'd0);
    check("abort", "diff", {24'b0, DIFF}, 32'd0);
    check("abort", "bout", {31'b0, BOUT}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("abort", "ovf", {31'b0, OVF}, 32'd0);
`endif
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort", "no_done", {31'b0, DONE}, 32'd0);
    end
    RST = 1'b0;
    last_diff = 8'h00;
    run_op(8'h09, 8'h04, 8'h05, 1'b0, 1'b0, 1'b0, "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
